// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor.
// One 4-bit lookahead group is resolved per stage. Unconsumed operand slices
// travel forward with the group carry, and finished sum slices ride along in
// the same vector, so the result leaves aligned from the last stage.
// Valid/ready handshake on both ends; a stalled output freezes the whole pipe.
module cla_pipe_adder #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NGRP = WIDTH / 4;
   localparam int LAST = NGRP - 1;

   if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
      $error("cla_pipe_adder: WIDTH must be a positive multiple of 4");
   end

   // Two-level lookahead for one 4-bit group: every carry is a flat
   // sum-of-products of g/p/c0, with no ripple between bit positions.
   // Returns {group carry-out, group sum}.
   function automatic logic [4:0] cla4(input logic [3:0] p,
                                       input logic [3:0] g,
                                       input logic       c0);
      logic [4:0] c;
      c[0] = c0;
      c[1] = g[0] | (p[0] & c0);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & c0);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c0);
      return {c[4], p ^ c[3:0]};
   endfunction

   // A held result that downstream refuses freezes every stage at once.
   logic stall;
   assign stall    = out_valid && !out_ready;
   assign in_ready = !stall;

   for (genvar k = 0; k < NGRP; k++) begin : g_stage
      localparam int LO = 4 * k;

      // Stage input: x_in holds finished sum bits below LO and operand A from
      // LO upward; y_in holds the effective B bits not yet consumed.
      logic [WIDTH-1:0]  x_in;
      logic [WIDTH-1:LO] y_in;
      logic              c_in;
      logic              v_in;
      logic [WIDTH-1:0]  x_nx;
      logic              c_nx;
      logic [4:0]        grp;

      // Resolve group k and splice its sum bits over the operand A slice.
      always_comb begin
         // NOTE: x_nx gets a full default before the partial overwrite so no
         // bit is left unassigned on any path and no latch is inferred.
         x_nx = x_in;
         grp  = cla4(x_in[LO+3:LO] ^ y_in[LO+3:LO],
                     x_in[LO+3:LO] & y_in[LO+3:LO], c_in);
         x_nx[LO+3:LO] = grp[3:0];
         c_nx = grp[4];
      end

      if (k == 0) begin : g_head
         assign x_in = a;
         assign y_in = sub ? ~b : b;
         assign c_in = cin ^ sub;
         assign v_in = in_valid;
      end else begin : g_reg
         // Stage register between group k-1 and group k; holds on stall.
         always_ff @(posedge clk) begin
            // NOTE: only the valid bit is reset; data registers are qualified
            // by it, so clearing them would cost reset fan-out for nothing.
            if (rst) begin
               v_in <= 1'b0;
            end else if (!stall) begin
               // NOTE: non-blocking assignments keep every stage sampling the
               // previous stage's pre-edge value, independent of block order.
               v_in <= g_stage[k-1].v_in;
               x_in <= g_stage[k-1].x_nx;
               y_in <= g_stage[k-1].y_in[WIDTH-1:LO];
               c_in <= g_stage[k-1].c_nx;
            end
         end
      end
   end

   // Output register: data loads only with a real result, so bubbles and
   // post-reset idle cycles leave sum/cout/ovf untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (!stall) begin
         out_valid <= g_stage[LAST].v_in;
         if (g_stage[LAST].v_in) begin
            sum  <= g_stage[LAST].x_nx;
            cout <= g_stage[LAST].c_nx;
            ovf  <= (g_stage[LAST].x_in[WIDTH-1] == g_stage[LAST].y_in[WIDTH-1])
                 && (g_stage[LAST].x_nx[WIDTH-1] != g_stage[LAST].x_in[WIDTH-1]);
         end
      end
   end

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Testbench for cla_pipe_adder: directed table, random streaming, bubbles,
// backpressure and mid-flight reset on a 16-bit instance, plus a width sweep
// on 4-, 8- and 32-bit instances against a behavioural arithmetic model.
module tb_cla_pipe_adder;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic        cin;
      logic        sub;
      logic [15:0] s;
      logic        co;
      logic        ov;
   } vec_t;

   typedef struct {
      logic [15:0] s;
      logic        co;
      logic        ov;
      int          due;
   } exp_t;

   localparam int NSW = 1024;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   // Edge counter used to timestamp acceptance and consumption.
   always @(posedge clk) cyc <= cyc + 1;

   logic        rst;
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [15:0] a, b, sum;

   cla_pipe_adder #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
      .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf)
   );

   logic        sw_valid, sw_ordy, sw_cin, sw_sub;
   logic [3:0]  a4, b4, s4;
   logic [7:0]  a8, b8, s8;
   logic [31:0] a32, b32, s32;
   logic        rdy4, ov4, co4, of4;
   logic        rdy8, ov8, co8, of8;
   logic        rdy32, ov32, co32, of32;

   cla_pipe_adder #(.WIDTH(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy4),
      .a(a4), .b(b4), .cin(sw_cin), .sub(sw_sub), .out_valid(ov4),
      .out_ready(sw_ordy), .sum(s4), .cout(co4), .ovf(of4)
   );
   cla_pipe_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy8),
      .a(a8), .b(b8), .cin(sw_cin), .sub(sw_sub), .out_valid(ov8),
      .out_ready(sw_ordy), .sum(s8), .cout(co8), .ovf(of8)
   );
   cla_pipe_adder #(.WIDTH(32)) dut32 (
      .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(rdy32),
      .a(a32), .b(b32), .cin(sw_cin), .sub(sw_sub), .out_valid(ov32),
      .out_ready(sw_ordy), .sum(s32), .cout(co32), .ovf(of32)
   );

   int   checks = 0;
   int   errors = 0;
   bit   lat_chk = 1'b0;
   exp_t q[$];
   vec_t vt[12];
   res_t e4[NSW];
   res_t e8[NSW];
   res_t e32[NSW];

   // Arithmetic reference: plain wide addition of a, effective B and c0.
   function automatic res_t model(input int w, input logic [31:0] ia,
                                  input logic [31:0] ib, input logic icin,
                                  input logic isub);
      logic [63:0] mask, bx, full;
      res_t r;
      mask  = (64'd1 << w) - 64'd1;
      bx    = isub ? (~{32'd0, ib}) & mask : {32'd0, ib} & mask;
      full  = ({32'd0, ia} & mask) + bx + {63'd0, icin ^ isub};
      r.sum  = full[31:0] & mask[31:0];
      r.cout = full[w];
      r.ovf  = (ia[w-1] == bx[w-1]) && (r.sum[w-1] != ia[w-1]);
      return r;
   endfunction

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One cycle on the 16-bit DUT: drive, score consumption/acceptance, edge.
   task automatic step(input logic iv, input logic [15:0] ia, input logic [15:0] ib,
                       input logic icin, input logic isub, input logic iordy,
                       input logic [15:0] es, input logic eco, input logic eov);
      exp_t e;
      in_valid  = iv;
      a         = ia;
      b         = ib;
      cin       = icin;
      sub       = isub;
      out_ready = iordy;
      #1;
      if (!rst) begin
         if (!out_ready) begin
            check("in_ready under backpressure", 64'(in_ready), 64'(!out_valid));
            if (out_valid && q.size() > 0)
               check("held result", 64'({sum, cout, ovf}), 64'({q[0].s, q[0].co, q[0].ov}));
         end
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected result: got sum %h with no beat outstanding (cycle %0d)", sum, cyc);
            end else begin
               e = q.pop_front();
               check("result", 64'({sum, cout, ovf}), 64'({e.s, e.co, e.ov}));
               if (lat_chk) check("latency", 64'(cyc), 64'(e.due));
            end
         end else if (lat_chk) begin
            check("out_valid slot", 64'(out_valid), 64'(q.size() > 0 && q[0].due == cyc));
         end
         if (in_valid && in_ready) q.push_back('{es, eco, eov, cyc + 4});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
   endtask

   task automatic rand_beat(input logic iordy);
      logic [15:0] ra, rb;
      logic rc, rs;
      res_t m;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      m  = model(16, {16'd0, ra}, {16'd0, rb}, rc, rs);
      step(1'b1, ra, rb, rc, rs, iordy, m.sum[15:0], m.cout, m.ovf);
   endtask

   initial begin
      vt[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vt[1]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vt[2]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vt[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
      vt[4]  = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
      vt[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
      vt[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vt[7]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
      vt[8]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
      vt[9]  = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
      vt[10] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
      vt[11] = '{16'h7FFF, 16'hFFFF, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};

      rst      = 1'b1;
      sw_valid = 1'b0;
      sw_ordy  = 1'b1;
      sw_cin   = 1'b0;
      sw_sub   = 1'b0;
      a4 = '0; b4 = '0; a8 = '0; b8 = '0; a32 = '0; b32 = '0;
      step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
      step(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
      rst       = 1'b0;
      out_ready = 1'b0;
      #1;
      check("reset out_valid", 64'(out_valid), 64'(0));
      check("reset outputs", 64'({sum, cout, ovf}), 64'(0));
      check("reset in_ready", 64'(in_ready), 64'(1));

      // Directed table, streamed back to back.
      lat_chk = 1'b1;
      foreach (vt[i]) step(1'b1, vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, 1'b1,
                           vt[i].s, vt[i].co, vt[i].ov);
      idle(6);
      check("table drained", 64'(q.size()), 64'(0));

      // 100 random back-to-back beats.
      for (int i = 0; i < 100; i++) rand_beat(1'b1);
      idle(6);
      check("stream drained", 64'(q.size()), 64'(0));

      // Alternating bubbles.
      for (int i = 0; i < 20; i++) begin
         if (i % 2 == 0) rand_beat(1'b1);
         else step(1'b0, 16'hDEAD, 16'hBEEF, 1'b1, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
      end
      idle(6);
      check("bubbles drained", 64'(q.size()), 64'(0));

      // Backpressure: five stalled cycles with a result pending.
      lat_chk = 1'b0;
      for (int i = 0; i < 6; i++) rand_beat(1'b1);
      for (int i = 0; i < 5; i++) begin
         check("stall out_valid", 64'(out_valid), 64'(1));
         rand_beat(1'b0);
      end
      for (int i = 0; i < 3; i++) rand_beat(1'b1);
      idle(8);
      check("backpressure drained", 64'(q.size()), 64'(0));

      // Reset with three beats in flight.
      lat_chk = 1'b1;
      for (int i = 0; i < 3; i++) rand_beat(1'b1);
      rst = 1'b1;
      rand_beat(1'b1);
      q.delete();
      rst       = 1'b0;
      out_ready = 1'b0;
      #1;
      check("mid reset out_valid", 64'(out_valid), 64'(0));
      check("mid reset outputs", 64'({sum, cout, ovf}), 64'(0));
      check("mid reset in_ready", 64'(in_ready), 64'(1));
      idle(6);
      step(1'b1, vt[1].a, vt[1].b, vt[1].cin, vt[1].sub, 1'b1, vt[1].s, vt[1].co, vt[1].ov);
      step(1'b1, vt[3].a, vt[3].b, vt[3].cin, vt[3].sub, 1'b1, vt[3].s, vt[3].co, vt[3].ov);
      idle(6);
      check("post reset drained", 64'(q.size()), 64'(0));

      // Width sweep: exhaustive 4-bit, random 8- and 32-bit.
      for (int i = 0; i < NSW + 10; i++) begin
         logic [9:0] iv;
         iv = 10'(i);
         if (i < NSW) begin
            sw_valid = 1'b1;
            a4       = iv[3:0];
            b4       = iv[7:4];
            sw_cin   = iv[8];
            sw_sub   = iv[9];
            a8       = 8'($urandom);
            b8       = 8'($urandom);
            a32      = $urandom;
            b32      = $urandom;
            e4[i]    = model(4, {28'd0, a4}, {28'd0, b4}, sw_cin, sw_sub);
            e8[i]    = model(8, {24'd0, a8}, {24'd0, b8}, sw_cin, sw_sub);
            e32[i]   = model(32, a32, b32, sw_cin, sw_sub);
         end else begin
            sw_valid = 1'b0;
         end
         #1;
         if (i - 1 >= 0 && i - 1 < NSW) begin
            check("w4 valid", 64'(ov4), 64'(1));
            check("w4 result", 64'({s4, co4, of4}),
                  64'({e4[i-1].sum[3:0], e4[i-1].cout, e4[i-1].ovf}));
         end else check("w4 idle", 64'(ov4), 64'(0));
         if (i - 2 >= 0 && i - 2 < NSW) begin
            check("w8 valid", 64'(ov8), 64'(1));
            check("w8 result", 64'({s8, co8, of8}),
                  64'({e8[i-2].sum[7:0], e8[i-2].cout, e8[i-2].ovf}));
         end else check("w8 idle", 64'(ov8), 64'(0));
         if (i - 8 >= 0 && i - 8 < NSW) begin
            check("w32 valid", 64'(ov32), 64'(1));
            check("w32 result", 64'({s32, co32, of32}),
                  64'({e32[i-8].sum, e32[i-8].cout, e32[i-8].ovf}));
         end else check("w32 idle", 64'(ov32), 64'(0));
         @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
- Each pipeline stage resolves one 4-bit group with full generate/propagate lookahead and registers the group carry into the next stage. Operand slices not yet consumed are skewed forward; finished sum slices are deskewed.
- Valid/ready handshake on both sides with whole-pipe stall. Intended as the wide datapath adder for accumulators and address generators.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4. A non-multiple is an elaboration error.
- NGRP, WIDTH/4, derived, not overridable; number of 4-bit groups, which equals pipeline depth.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block accepts the beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add) or borrow-in (sub).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB. In sub mode, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Arithmetic:
  - Effective B: bx = sub ? ~b : b.
  - Effective carry-in: c0 = cin ^ sub.
  - {cout, sum} = a + bx + c0, evaluated modulo 2^(WIDTH+1).
  - Add: sum = a+b+cin. Sub: sum = a-b-cin.
  - ovf = (a[MSB] == bx[MSB]) && (sum[MSB] != a[MSB]).
- Group logic: per 4-bit group, p = a^bx and g = a&bx. Internal carries and group carry-out use full two-level lookahead, with no ripple inside the group. Group sum = p ^ carries.
- Pipeline:
  - Stage k (k = 0..NGRP-1) computes group k from the registered carry of stage k-1; stage 0 uses c0.
  - Each stage carries a valid bit.
  - Latency is exactly NGRP cycles from the accepting handshake (in_valid && in_ready) to the corresponding out_valid, assuming no stall.
  - Throughput is 1 beat/cycle.
- Handshake:
  - stall = out_valid && !out_ready.
  - in_ready = !stall, combinational from out_valid and out_ready only; it must not depend on in_valid.
  - During a stall, all stage registers, including valid bits and output registers, hold.
  - When not stalled, the pipe advances. Stage 0 loads valid = in_valid.
  - Bubbles (in_valid=0) propagate as valid=0 slots and are never presented as results.
  - sum, cout and ovf are registered and held stable while out_valid=1 and out_ready=0.
  - A result is consumed on out_valid && out_ready.
  - Data outputs are don't-care when out_valid=0, but must not change during a stall.
- Reset (any cycle, including mid-operation or mid-stall):
  - All stage valid bits clear to 0; in-flight beats are discarded.
  - out_valid=0, sum=0, cout=0, ovf=0.
  - in_ready=1 in the first cycle after reset deasserts.
  - Inputs are ignored during the rst cycle.
- Simultaneous events: a beat accepted in the same cycle a result is consumed is legal (steady-state streaming). rst has priority over everything.
- WIDTH=4: single stage, latency 1. Behaviour equals a registered 4-bit CLA with handshake.
- Ordering: results leave in acceptance order; no reordering, duplication or loss.

Test Plan:
- WIDTH=16, out_ready=1: a=0xFFFF, b=0x0001, cin=0, sub=0 -> after 4 cycles sum=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Then a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1. Then a=0x0010, b=0x0003, sub=1, cin=1 -> sum=0x000C, cout=1.
- Streaming: 100 back-to-back random beats with in_valid=1, out_ready=1 -> one result per cycle, each matching the reference model, latency exactly 4, in order.
- Backpressure: stream beats; drop out_ready for 5 cycles with a result pending -> in_ready=0 throughout, sum/cout/ovf/out_valid held constant. On release, no beat is lost or duplicated.
- Bubbles and reset: inject alternating in_valid=1/0 -> out_valid pattern mirrors input delayed by 4. Assert rst for 1 cycle with 3 beats in flight -> out_valid stays 0 until new beats arrive, all outputs 0, in_ready=1 the next cycle.
- Width sweep: WIDTH=4, 8 and 32 with exhaustive (WIDTH=4) or random operands/cin/sub -> latency = WIDTH/4, results match the model including cout and ovf.
